// File: rtl/avl_burst_ram_responder.sv
// avl_burst_ram_responder: block-RAM stand-in for the DDR3 controller avl_* port.
// Models calibration delay, ready back-pressure with optional LFSR stalls,
// byte-enabled burst writes and fixed-latency pipelined burst reads.
module avl_burst_ram_responder #(
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 128,
    parameter int SIZE_WIDTH     = 8,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 4,
    parameter int INIT_CYCLES    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_en,
    input  logic                    avl_burstbegin,
    input  logic [ADDR_WIDTH-1:0]   avl_address,
    input  logic [SIZE_WIDTH-1:0]   avl_size,
    input  logic                    avl_read_req,
    input  logic                    avl_write_req,
    input  logic [DATA_WIDTH-1:0]   avl_wdata,
    input  logic [DATA_WIDTH/8-1:0] avl_be,
    output logic                    avl_ready,
    output logic [DATA_WIDTH-1:0]   avl_rdata,
    output logic                    avl_rdata_valid,
    output logic                    calib_done,
    output logic                    proto_err,
    output logic [31:0]             wr_beats,
    output logic [31:0]             rd_beats
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int AW     = MEM_DEPTH_LOG2;
    localparam int PIPE   = READ_LATENCY - 1;  // RAM read register counts as the first stage
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [1:0] {INIT, IDLE, WR_BURST, RD_BURST} state_t;

    state_t                  state, state_nxt;
    logic [15:0]             lfsr;
    logic [INIT_W-1:0]       init_cnt;
    logic [AW-1:0]           base_q, base_nxt;
    logic [SIZE_WIDTH-1:0]   size_q, size_nxt;
    logic [SIZE_WIDTH-1:0]   beat_q, beat_nxt;
    logic [SIZE_WIDTH-1:0]   eff_size;
    logic                    stall;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic                    rd_issue;
    logic [AW-1:0]           rd_addr;
    logic                    err_set;

    logic [DATA_WIDTH-1:0]   mem [0:(2**AW)-1];
    logic [PIPE-1:0]         vld_pipe;
    logic [DATA_WIDTH-1:0]   dat_pipe [PIPE];

    // Upper address bits alias onto the RAM and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^avl_address[ADDR_WIDTH-1:AW];

    assign stall     = stall_en && (lfsr[1:0] == 2'b00);
    assign avl_ready = ((state == IDLE) || (state == WR_BURST)) && !stall;
    assign eff_size  = (avl_size == '0) ? SIZE_WIDTH'(1) : avl_size;

    // Next-state and datapath control; writes take priority over reads in IDLE.
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        size_nxt  = size_q;
        beat_nxt  = beat_q;
        wr_en     = 1'b0;
        wr_addr   = base_q + AW'(beat_q);
        rd_issue  = 1'b0;
        rd_addr   = base_q + AW'(beat_q);
        err_set   = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt >= INIT_W'(INIT_CYCLES - 1)) state_nxt = IDLE;
            end
            IDLE: begin
                if (avl_ready && avl_write_req) begin
                    wr_en     = 1'b1;
                    wr_addr   = avl_address[AW-1:0];
                    base_nxt  = avl_address[AW-1:0];
                    size_nxt  = eff_size;
                    beat_nxt  = SIZE_WIDTH'(1);
                    state_nxt = (eff_size == SIZE_WIDTH'(1)) ? IDLE : WR_BURST;
                    err_set   = avl_read_req || (avl_size == '0) || !avl_burstbegin;
                end else if (avl_ready && avl_read_req) begin
                    base_nxt  = avl_address[AW-1:0];
                    size_nxt  = eff_size;
                    beat_nxt  = '0;
                    state_nxt = RD_BURST;
                    err_set   = (avl_size == '0);
                end
            end
            WR_BURST: begin
                if (avl_ready && avl_write_req) begin
                    wr_en    = 1'b1;
                    beat_nxt = beat_q + SIZE_WIDTH'(1);
                    if (beat_q == size_q - SIZE_WIDTH'(1)) state_nxt = IDLE;
                end
            end
            RD_BURST: begin
                rd_issue = 1'b1;
                beat_nxt = beat_q + SIZE_WIDTH'(1);
                if (beat_q == size_q - SIZE_WIDTH'(1)) state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Control state, calibration counter, LFSR and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            lfsr       <= 16'hACE1;
            init_cnt   <= '0;
            base_q     <= '0;
            size_q     <= '0;
            beat_q     <= '0;
            calib_done <= 1'b0;
            proto_err  <= 1'b0;
            wr_beats   <= '0;
            rd_beats   <= '0;
        end else begin
            state  <= state_nxt;
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            base_q <= base_nxt;
            size_q <= size_nxt;
            beat_q <= beat_nxt;
            if (state == INIT) init_cnt <= init_cnt + INIT_W'(1);
            if (state == INIT && state_nxt == IDLE) calib_done <= 1'b1;
            if (err_set) proto_err <= 1'b1;
            if (wr_en) wr_beats <= wr_beats + 32'd1;
            if (avl_rdata_valid) rd_beats <= rd_beats + 32'd1;
        end
    end

    // Byte-enabled RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            for (int b = 0; b < BE_W; b++)
                if (avl_be[b]) mem[wr_addr][8*b +: 8] <= avl_wdata[8*b +: 8];
        end
    end

    // Read pipeline: registered RAM read followed by delay stages; never stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < PIPE; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= rd_issue;
            dat_pipe[0] <= mem[rd_addr];
            for (int i = 1; i < PIPE; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign avl_rdata_valid = vld_pipe[PIPE-1];
    assign avl_rdata       = dat_pipe[PIPE-1];

endmodule

// File: tb/tb_avl_burst_ram_responder.sv
// Testbench for avl_burst_ram_responder: reference memory plus a queue of
// expected read beats stamped with the cycle they must appear in.
module tb_avl_burst_ram_responder;

    localparam int DW = 128, BW = 16, AWD = 25, SW = 8, LAT = 4, INIT = 64, DEPTH = 1024;

    logic           clk = 1'b0;
    logic           reset, stall_en, avl_burstbegin, avl_read_req, avl_write_req;
    logic [AWD-1:0] avl_address;
    logic [SW-1:0]  avl_size;
    logic [DW-1:0]  avl_wdata;
    logic [BW-1:0]  avl_be;
    logic           avl_ready, avl_rdata_valid, calib_done, proto_err;
    logic [DW-1:0]  avl_rdata;
    logic [31:0]    wr_beats, rd_beats;

    avl_burst_ram_responder #(
        .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .SIZE_WIDTH(SW),
        .MEM_DEPTH_LOG2(10), .READ_LATENCY(LAT), .INIT_CYCLES(INIT)
    ) dut (
        .clk(clk), .reset(reset), .stall_en(stall_en),
        .avl_burstbegin(avl_burstbegin), .avl_address(avl_address), .avl_size(avl_size),
        .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
        .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_ready(avl_ready),
        .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
        .calib_done(calib_done), .proto_err(proto_err),
        .wr_beats(wr_beats), .rd_beats(rd_beats)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int wr_cnt = 0, rd_exp = 0;
    int rdy_lo = 0, rdy_n = 0;
    bit cnt_rdy = 0;

    logic [DW-1:0] mm [DEPTH];
    typedef struct { int cyc; logic [DW-1:0] d; } exp_t;
    exp_t eq[$];

    typedef struct {
        int waddr; int wsize; logic [7:0] seed; logic [BW-1:0] be;
        int raddr; int rsize; logic [DW-1:0] exp;
    } vec_t;
    vec_t vt[6];

    function automatic logic [DW-1:0] pat(input logic [7:0] s);
        return {16{s}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle: a beat must appear exactly when the model scheduled it.
    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL rbeat_missed: beat due cycle %0d never checked", eq[0].cyc);
            void'(eq.pop_front());
        end
        if (eq.size() > 0 && eq[0].cyc == cyc) begin
            checks++;
            if (avl_rdata_valid !== 1'b1 || avl_rdata !== eq[0].d) begin
                errors++;
                $display("FAIL rbeat cyc %0d: valid=%b data=%h expected valid=1 data=%h",
                         cyc, avl_rdata_valid, avl_rdata, eq[0].d);
            end
            void'(eq.pop_front());
            rd_exp++;
        end else if (avl_rdata_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL rbeat cyc %0d: valid=%b expected valid=0", cyc, avl_rdata_valid);
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cnt_rdy) begin rdy_n++; if (!avl_ready) rdy_lo++; end
            if (avl_ready) begin ok = 1; return; end
        end
        checks++; errors++;
        $display("FAIL ready_timeout: got no ready in 2000 cycles expected ready");
    endtask

    task automatic wr_burst(input int addr, input int size, input logic [7:0] seed,
                            input logic [BW-1:0] be, input bit bb, input bit also_rd);
        int n = (size == 0) ? 1 : size;
        bit ok;
        logic [DW-1:0] wd;
        for (int b = 0; b < n; b++) begin
            wd             = pat(8'(seed + b));
            avl_write_req  = 1'b1;
            avl_read_req   = (b == 0) && also_rd;
            avl_burstbegin = (b == 0) ? bb : 1'b0;
            avl_address    = (b == 0) ? AWD'(addr) : AWD'($urandom);
            avl_size       = (b == 0) ? SW'(size) : SW'($urandom);
            avl_wdata      = wd;
            avl_be         = be;
            wait_ready(ok);
            if (!ok) break;
            for (int i = 0; i < BW; i++)
                if (be[i]) mm[(addr + b) % DEPTH][8*i +: 8] = wd[8*i +: 8];
            wr_cnt++;
            @(posedge clk); #1;
        end
        avl_write_req = 1'b0; avl_read_req = 1'b0; avl_burstbegin = 1'b0;
    endtask

    task automatic rd_burst(input int addr, input int size, input bit quick,
                            output logic [DW-1:0] first);
        int n = (size == 0) ? 1 : size;
        int t;
        bit ok, busy_rdy;
        first = '0;
        busy_rdy = 0;
        avl_read_req = 1'b1; avl_burstbegin = 1'b1;
        avl_address = AWD'(addr); avl_size = SW'(size);
        wait_ready(ok);
        if (!ok) begin avl_read_req = 1'b0; avl_burstbegin = 1'b0; return; end
        t = cyc;
        for (int k = 0; k < n; k++) eq.push_back('{t + LAT + k, mm[(addr + k) % DEPTH]});
        @(posedge clk); #1;
        avl_read_req = 1'b0; avl_burstbegin = 1'b0;
        for (int k = 1; k <= (quick ? n : n + LAT); k++) begin
            @(negedge clk);
            if (k <= n && avl_ready) busy_rdy = 1;
            if (k == n + 1 && !stall_en) chk("rd_ready_after", avl_ready, 1);
            if (k == LAT) first = avl_rdata;
        end
        chk("rd_busy_ready", busy_rdy, 0);
        @(posedge clk); #1;
    endtask

    task automatic calib_wait(output int n, output bit early);
        n = 0; early = 0;
        @(negedge clk);
        while (!calib_done && n < 300) begin
            if (avl_ready) early = 1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && eq.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", eq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit early;
        logic [DW-1:0] first;

        vt[0] = '{32'h010,  8, 8'h11, 16'hFFFF, 32'h013, 4, pat(8'h14)};
        vt[1] = '{32'h3FE,  4, 8'hA0, 16'hFFFF, 32'h000, 2, pat(8'hA2)};
        vt[2] = '{32'h020,  1, 8'hFF, 16'hFFFF, 32'h020, 1, pat(8'hFF)};
        vt[3] = '{32'h020,  1, 8'h00, 16'h00FF, 32'h020, 1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}};
        vt[4] = '{32'h7FE,  2, 8'h30, 16'hFFFF, 32'h3FF, 1, pat(8'h31)};
        vt[5] = '{32'h1400, 1, 8'hC3, 16'hFFFF, 32'h800, 1, pat(8'hC3)};

        reset = 1; stall_en = 0; avl_burstbegin = 0; avl_read_req = 0; avl_write_req = 0;
        avl_address = '0; avl_size = '0; avl_wdata = '0; avl_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", avl_ready, 0);
        chk("rst_valid", avl_rdata_valid, 0);
        chk("rst_rdata", avl_rdata, 0);
        chk("rst_calib", calib_done, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_wr_beats", wr_beats, 0);
        chk("rst_rd_beats", rd_beats, 0);

        // Calibration delay.
        @(posedge clk); #1 reset = 0;
        calib_wait(n, early);
        chk("calib_cycle", n, INIT);
        chk("calib_ready", avl_ready, 1);
        chk("calib_no_early_ready", early, 0);
        @(posedge clk); #1;

        // Known contents everywhere so random reads have a defined model.
        for (int i = 0; i < 8; i++) wr_burst(i * 128, 128, 8'(i * 128), '1, 1, 0);
        chk("fill_wr_beats", wr_beats, wr_cnt);

        // Table: write, read back, compare the first returned beat to a constant.
        for (int v = 0; v < 6; v++) begin
            wr_burst(vt[v].waddr, vt[v].wsize, vt[v].seed, vt[v].be, 1, 0);
            rd_burst(vt[v].raddr, vt[v].rsize, 0, first);
            chk($sformatf("vec%0d_rdata", v), first, vt[v].exp);
        end
        chk("tbl_wr_beats", wr_beats, wr_cnt);

        // Back-to-back reads must stream with no gap.
        rd_burst(32'h010, 8, 1, first);
        rd_burst(32'h3FE, 4, 1, first);
        drain();

        // Stalled 256-beat stream.
        stall_en = 1; cnt_rdy = 1;
        wr_burst(32'h200, 128, 8'h40, '1, 1, 0);
        wr_burst(32'h280, 128, 8'hC0, '1, 1, 0);
        cnt_rdy = 0;
        rd_burst(32'h200, 128, 1, first);
        rd_burst(32'h280, 128, 1, first);
        stall_en = 0;
        drain();
        checks++;
        if (rdy_n == 0 || rdy_lo * 100 < rdy_n * 12 || rdy_lo * 100 > rdy_n * 40) begin
            errors++;
            $display("FAIL stall_ratio: got %0d low of %0d samples expected about 25%%", rdy_lo, rdy_n);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            stall_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                wr_burst($urandom_range(0, 4095), $urandom_range(1, 16), 8'($urandom),
                         BW'($urandom), 1, 0);
            else
                rd_burst($urandom_range(0, 4095), $urandom_range(1, 16),
                         1'($urandom_range(0, 1)), first);
        end
        stall_en = 0;
        drain();
        chk("rand_rd_beats", rd_beats, rd_exp);
        chk("rand_wr_beats", wr_beats, wr_cnt);
        chk("rand_proto_clean", proto_err, 0);

        // Simultaneous read and write: write wins, read dropped.
        wr_burst(32'h050, 1, 8'h5A, '1, 1, 1);
        repeat (LAT + 3) @(posedge clk); #1;
        chk("rdwr_proto", proto_err, 1);
        chk("rdwr_wr_beats", wr_beats, wr_cnt);
        rd_burst(32'h050, 1, 0, first);
        chk("rdwr_data", first, pat(8'h5A));

        // Reset in the middle of a read burst.
        avl_read_req = 1; avl_burstbegin = 1; avl_address = '0; avl_size = 8'd16;
        wait_ready(early);
        n = cyc;
        for (int k = 0; k < 16; k++) eq.push_back('{n + LAT + k, mm[k]});
        @(posedge clk); #1 avl_read_req = 0; avl_burstbegin = 0;
        repeat (5) @(posedge clk);
        #1 reset = 1;
        n = cyc;
        while (eq.size() > 0 && eq[eq.size()-1].cyc > n) void'(eq.pop_back());
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_calib", calib_done, 0);
        chk("mid_rst_proto", proto_err, 0);
        chk("mid_rst_wr_beats", wr_beats, 0);
        @(posedge clk); #1 reset = 0;
        wr_cnt = 0; rd_exp = 0;
        calib_wait(n, early);
        chk("recal_cycle", n, INIT);
        @(posedge clk); #1;
        rd_burst(32'h3FE, 4, 0, first);
        chk("post_rst_rd_beats_settle", eq.size(), 0);

        // Zero-size commands behave as single beats and flag an error.
        wr_burst(32'h060, 0, 8'h77, '1, 1, 0);
        @(negedge clk);
        chk("size0_ready", avl_ready, 1);
        chk("size0_proto", proto_err, 1);
        chk("size0_wr_beats", wr_beats, wr_cnt);
        @(posedge clk); #1;
        rd_burst(32'h060, 0, 0, first);
        chk("size0_rdata", first, pat(8'h77));
        drain();
        chk("size0_rd_beats", rd_beats, rd_exp);

        // Missing burstbegin on the first write beat.
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        wr_cnt = 0; rd_exp = 0;
        calib_wait(n, early);
        @(posedge clk); #1;
        chk("nobb_proto_clear", proto_err, 0);
        wr_burst(32'h070, 2, 8'h90, '1, 0, 0);
        @(negedge clk);
        chk("nobb_proto", proto_err, 1);
        chk("nobb_wr_beats", wr_beats, 2);
        @(posedge clk); #1;
        rd_burst(32'h070, 2, 0, first);
        chk("nobb_rdata", first, pat(8'h90));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
